// File: rtl/uart_bram_pkg.sv
// Shared command/response codes and FSM state encoding for the UART-to-SRAM command parser.
package uart_bram_pkg;

    localparam logic [7:0] CMD_WR      = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD      = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_BADCMD  = 8'h3F;  // '?'
    localparam logic [7:0] RSP_BADADDR = 8'h21;  // '!'

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_GET_ADDR = 3'd1;
    localparam logic [2:0] ST_GET_DATA = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_READ     = 3'd4;
    localparam logic [2:0] ST_SEND     = 3'd5;

    localparam int DEFAULT_TIMEOUT = 2700000;

endpackage

// File: rtl/uart_bram_cmd_timeout.sv
// Inter-byte timeout: counts enabled cycles without clr, pulses expire on the CYCLES-th one.
// Latency: expire is combinational from the count; the count self-clears on expiry.
module cmd_timeout #(
    parameter int CYCLES = 2700000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    assign expire = en && !clr && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || !en || expire) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_bram_cmd.sv
// Parses 'W',addr,data / 'R',addr byte commands from the UART into Gowin SP SRAM accesses.
// Latency: write 2, read RD_LATENCY+2, error 1 cycle(s) from last byte to tx_valid.
// Backpressure: response held on tx_valid until tx_ready; bytes arriving meanwhile are dropped.
module uart_bram_cmd
    import uart_bram_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int RD_LATENCY     = 2,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              bram_ce,
    output logic              bram_oce,
    output logic              bram_wre,
    output logic              bram_reset,
    output logic [ADDR_W-1:0] bram_ad,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic              busy,
    output logic              err_overrun
);

    localparam int RDW = $clog2(RD_LATENCY + 1);
    localparam logic [RDW-1:0] RD_LAST = RDW'(RD_LATENCY);

    logic [2:0]     state;
    logic           isWrite;
    logic [RDW-1:0] rdCnt;
    logic           toEn;
    logic           toExpire;
    logic           addrBad;

    assign toEn    = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    // Reject rather than truncate: any bit above the address field makes it out of range.
    assign addrBad = (rx_data >> ADDR_W) != '0;

    cmd_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (toEn),
        .clr    (rx_valid),
        .expire (toExpire)
    );

    assign tx_valid   = (state == ST_SEND);
    assign bram_ce    = (state == ST_WRITE) || (state == ST_READ);
    assign bram_oce   = (state == ST_READ);
    assign bram_wre   = (state == ST_WRITE);
    assign busy       = (state != ST_IDLE);
    assign bram_reset = ~rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            isWrite     <= 1'b0;
            rdCnt       <= '0;
            tx_data     <= '0;
            bram_ad     <= '0;
            bram_din    <= '0;
            err_overrun <= 1'b0;
        end else begin
            if (rx_valid && (state == ST_WRITE || state == ST_READ || state == ST_SEND)) begin
                err_overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == DATA_W'(CMD_WR)) begin
                            isWrite <= 1'b1;
                            state   <= ST_GET_ADDR;
                        end else if (rx_data == DATA_W'(CMD_RD)) begin
                            isWrite <= 1'b0;
                            state   <= ST_GET_ADDR;
                        end else begin
                            tx_data <= DATA_W'(RSP_BADCMD);
                            state   <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (rx_valid) begin
                        if (addrBad) begin
                            tx_data <= DATA_W'(RSP_BADADDR);
                            state   <= ST_SEND;
                        end else begin
                            bram_ad <= rx_data[ADDR_W-1:0];
                            rdCnt   <= '0;
                            state   <= isWrite ? ST_GET_DATA : ST_READ;
                        end
                    end else if (toExpire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_GET_DATA: begin
                    if (rx_valid) begin
                        bram_din <= rx_data;
                        state    <= ST_WRITE;
                    end else if (toExpire) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    tx_data <= DATA_W'(RSP_OK);
                    state   <= ST_SEND;
                end
                ST_READ: begin
                    // One extra cycle beyond RD_LATENCY covers the request edge itself.
                    if (rdCnt == RD_LAST) begin
                        tx_data <= bram_dout;
                        state   <= ST_SEND;
                    end else begin
                        rdCnt <= rdCnt + RDW'(1);
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bram_cmd.sv
// Bench for uart_bram_cmd: directed vector table, multi-cycle corner sequences, random commands.
`timescale 1ns/1ps
module tb_uart_bram_cmd;

    localparam int TO  = 40;
    localparam int RDL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       bram_ce, bram_oce, bram_wre, bram_reset;
    logic [3:0] bram_ad;
    logic [7:0] bram_din;
    logic [7:0] bram_dout = 8'h00;
    logic       busy, err_overrun;

    uart_bram_cmd #(
        .ADDR_W(4), .DATA_W(8), .RD_LATENCY(RDL), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bram_ce(bram_ce), .bram_oce(bram_oce), .bram_wre(bram_wre), .bram_reset(bram_reset),
        .bram_ad(bram_ad), .bram_din(bram_din), .bram_dout(bram_dout),
        .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    // Pipeline-mode single-port SRAM (array stage + output register).
    logic [7:0] mem [16];
    logic [7:0] stage = 8'h00;
    always @(posedge clk) begin
        if (bram_ce) begin
            if (bram_wre) mem[bram_ad] <= bram_din;
            else          stage <= mem[bram_ad];
        end
        if (bram_oce) bram_dout <= stage;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int readyMode = 0;  // 0 low, 1 high, 2 random
    always @(posedge clk) begin
        #2;
        case (readyMode)
            0:       tx_ready = 1'b0;
            1:       tx_ready = 1'b1;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int wreCnt = 0, ceCnt = 0, txvCnt = 0;
    logic [3:0] lastAd = 4'h0;
    logic [7:0] lastDin = 8'h00;
    always @(negedge clk) begin
        if (bram_wre) begin
            wreCnt  <= wreCnt + 1;
            lastAd  <= bram_ad;
            lastDin <= bram_din;
        end
        if (bram_ce)  ceCnt  <= ceCnt + 1;
        if (tx_valid) txvCnt <= txvCnt + 1;
    end

    int nCmp = 0, nBad = 0;
    int lastStrobe = 0;
    logic [7:0] shadow [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data    = b;
        rx_valid   = 1'b1;
        lastStrobe = cyc;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic waitRsp(output logic [7:0] got, output int lat, output bit ok);
        ok = 1'b0; lat = -1; got = 8'h00;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (tx_valid && lat < 0) lat = cyc - lastStrobe;
            if (tx_valid && tx_ready) begin
                got = tx_data;
                ok  = 1'b1;
            end
        end
        if (ok) @(posedge clk);
    endtask

    task automatic runCmd(input int n, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] expRsp, input int expLat,
                          input string name);
        logic [7:0] got;
        int lat;
        bit ok;
        sendByte(b0);
        if (n > 1) sendByte(b1);
        if (n > 2) sendByte(b2);
        waitRsp(got, lat, ok);
        if (!ok) begin
            nCmp++; nBad++;
            $display("FAIL %s: no response within bound", name);
        end else begin
            check({name, " rsp"}, 32'(got), 32'(expRsp));
            check({name, " lat"}, 32'(lat), 32'(expLat));
        end
    endtask

    function automatic bit isCmd(input logic [7:0] c);
        return c == 8'h57 || c == 8'h52;
    endfunction

    function automatic int refLen(input logic [7:0] c, input logic [7:0] a);
        if (!isCmd(c)) return 1;
        if (a >= 16 || c == 8'h52) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] refRsp(input logic [7:0] c, input logic [7:0] a);
        if (!isCmd(c)) return 8'h3F;
        if (a >= 16)    return 8'h21;
        if (c == 8'h57) return 8'h4B;
        return shadow[a[3:0]];
    endfunction

    function automatic int refLat(input logic [7:0] c, input logic [7:0] a);
        if (!isCmd(c) || a >= 16) return 1;
        return (c == 8'h57) ? 2 : RDL + 2;
    endfunction

    task automatic modelApply(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        if (c == 8'h57 && a < 16) shadow[a[3:0]] = d;
    endtask

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic [7:0] rsp;
        int         lat;
        int         wre;
        int         ce;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, c0, t0;
        bit found;
        logic [7:0] c, a, d, got;
        int lat;
        bit ok;

        vecs[0] = '{3, 8'h57, 8'h03, 8'hA5, 8'h4B, 2, 1, 1};
        vecs[1] = '{2, 8'h52, 8'h03, 8'h00, 8'hA5, 4, 0, 3};
        vecs[2] = '{1, 8'h41, 8'h00, 8'h00, 8'h3F, 1, 0, 0};
        vecs[3] = '{2, 8'h52, 8'h10, 8'h00, 8'h21, 1, 0, 0};
        vecs[4] = '{3, 8'h57, 8'h0F, 8'h5A, 8'h4B, 2, 1, 1};
        vecs[5] = '{2, 8'h52, 8'h0F, 8'h00, 8'h5A, 4, 0, 3};
        vecs[6] = '{2, 8'h57, 8'h20, 8'h00, 8'h21, 1, 0, 0};
        vecs[7] = '{2, 8'h52, 8'h00, 8'h00, 8'h00, 4, 0, 3};

        for (int i = 0; i < 16; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end

        // Reset state, checked while rst_n is still low.
        #3;
        check("reset outputs", {tx_valid, tx_data, bram_ce, bram_oce, bram_wre, bram_ad,
                                bram_din, busy, err_overrun}, '0);
        check("reset bram_reset", 32'(bram_reset), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("release bram_reset", 32'(bram_reset), 0);
        readyMode = 1;

        foreach (vecs[i]) begin
            w0 = wreCnt; c0 = ceCnt;
            runCmd(vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].rsp, vecs[i].lat,
                   $sformatf("vec%0d", i));
            check($sformatf("vec%0d wre pulses", i), 32'(wreCnt - w0), 32'(vecs[i].wre));
            check($sformatf("vec%0d ce cycles", i), 32'(ceCnt - c0), 32'(vecs[i].ce));
            if (vecs[i].wre != 0) begin
                check($sformatf("vec%0d wre ad/din", i), {28'h0, lastAd, lastDin},
                      {28'h0, vecs[i].b1[3:0], vecs[i].b2});
            end
            modelApply(vecs[i].b0, vecs[i].b1, vecs[i].b2);
        end

        // Full address sweep, data = ~addr.
        for (int i = 0; i < 16; i++) begin
            a = 8'(i); d = ~a;
            runCmd(3, 8'h57, a, d, refRsp(8'h57, a), refLat(8'h57, a), $sformatf("sweep wr%0d", i));
            modelApply(8'h57, a, d);
        end
        for (int i = 0; i < 16; i++) begin
            a = 8'(i);
            runCmd(2, 8'h52, a, 8'h00, 8'(~a), refLat(8'h52, a), $sformatf("sweep rd%0d", i));
        end

        // Timeout after 'W',0x02 with no data byte.
        w0 = wreCnt; t0 = txvCnt;
        sendByte(8'h57);
        sendByte(8'h02);
        repeat (TO - 5) @(negedge clk);
        check("timeout busy before", 32'(busy), 1);
        repeat (10) @(negedge clk);
        check("timeout busy after", 32'(busy), 0);
        check("timeout no response", 32'(txvCnt - t0), 0);
        check("timeout no write", 32'(wreCnt - w0), 0);
        runCmd(2, 8'h52, 8'h02, 8'h00, shadow[2], RDL + 2, "rd after timeout");

        // Response stalled by tx_ready low, with an overrun byte during the stall.
        check("overrun clear", 32'(err_overrun), 0);
        readyMode = 0;
        sendByte(8'h52);
        sendByte(8'h03);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx_valid) found = 1'b1;
        end
        check("stall valid seen", 32'(found), 1);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            rx_data  = 8'h55;
            rx_valid = (i == 20);
            @(negedge clk);
            check($sformatf("stall hold %0d", i), {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, shadow[3]});
        end
        rx_valid = 1'b0;
        check("overrun set", 32'(err_overrun), 1);
        readyMode = 1;
        waitRsp(got, lat, ok);
        check("stall delivered", 32'(ok), 1);
        check("stall rsp", 32'(got), 32'(shadow[3]));
        t0 = txvCnt;
        repeat (5) @(negedge clk);
        check("stall single rsp", 32'(txvCnt - t0), 0);
        check("stall idle", 32'(busy), 0);

        // Reset while waiting for the data byte of a write.
        w0 = wreCnt;
        sendByte(8'h57);
        sendByte(8'h05);
        check("getdata busy", 32'(busy), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("rst getdata outs", {tx_valid, bram_ce, bram_wre, bram_oce, busy, err_overrun}, 0);
        check("rst getdata bram_reset", 32'(bram_reset), 1);
        sendByte(8'h77);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst getdata release", 32'(bram_reset), 0);
        check("rst getdata no write", 32'(wreCnt - w0), 0);
        runCmd(2, 8'h52, 8'h05, 8'h00, shadow[5], RDL + 2, "rd after reset");

        // Reset while a response is pending.
        readyMode = 0;
        sendByte(8'h41);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx_valid) found = 1'b1;
        end
        check("send pending", 32'(found), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst send tx_valid", 32'(tx_valid), 0);
        check("rst send busy/bram_reset", {busy, bram_reset}, 32'b01);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        readyMode = 2;
        repeat (2) @(negedge clk);
        check("rst send quiet", 32'(tx_valid), 0);

        // Random commands against the reference model, random tx_ready.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 9))
                0: begin
                    do c = 8'($urandom); while (isCmd(c));
                    a = 8'h00;
                end
                1: begin c = 8'h52; a = 8'($urandom_range(16, 255)); end
                2: begin c = 8'h57; a = 8'($urandom_range(16, 255)); end
                3, 4, 5, 6: begin c = 8'h57; a = 8'($urandom_range(0, 15)); end
                default: begin c = 8'h52; a = 8'($urandom_range(0, 15)); end
            endcase
            d = 8'($urandom);
            runCmd(refLen(c, a), c, a, d, refRsp(c, a), refLat(c, a), $sformatf("rand%0d", k));
            modelApply(c, a, d);
        end

        readyMode = 1;
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
